// File: rtl/retire_trace_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_tx_pkg
// Purpose  : Shared types for the retire trace transmitter: frame type codes,
//            retire record layout, and the header byte encoder.
// Contents : t_rob_id, t_trace_frame_type, t_trace_rec, make_header()
// Revision : 1.0 - initial release
// ============================================================================
package retire_trace_tx_pkg;

  typedef logic [4:0] t_rob_id;

  typedef enum logic [1:0] {
    FT_RETIRE   = 2'b00,
    FT_OVERFLOW = 2'b01,
    FT_HANG     = 2'b10,
    FT_RSVD     = 2'b11
  } t_trace_frame_type;

  // One buffered retire event; packed so it can sit in a generic FIFO.
  typedef struct packed {
    logic [31:0] pc;
    t_rob_id     robid;
    logic        dst_valid;
    logic [4:0]  dst_reg;
    logic [31:0] dst_data;
    logic        nuke;
  } t_trace_rec;

  // Header byte: [7:6] type, [5] nuke, [4] dst_valid, [3:0] robid low nibble.
  function automatic logic [7:0] make_header(t_trace_frame_type ft, logic nuke,
                                             logic dst_valid, logic [3:0] robid_lo);
    return {ft, nuke, dst_valid, robid_lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/retire_trace_tx_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gen_fifo
// Purpose  : Generic synchronous FIFO with occupancy count. Head entry is
//            visible on o_pop_data while non-empty (show-ahead).
// Ports    : clk, reset        - clock, synchronous active-high reset
//            i_push/i_push_data - write request and data (ignored when full)
//            i_pop              - advance head (ignored when empty)
//            o_pop_data         - current head entry
//            o_count            - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module gen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push  = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop   = i_pop && (r_count != '0);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/retire_trace_tx.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_tx
// Purpose  : Buffers retired-instruction records and serialises them as byte
//            frames on a valid/ready trace port. Also emits overflow frames
//            (dropped record count) and hang frames (watchdog on retires).
// Ports    : clk, reset            - clock, synchronous active-high reset
//            retire_*              - one retire event per cycle when valid
//            trace_valid/data/last - output byte stream, trace_ready = sink
//            drop_total            - saturating dropped-record count
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_tx
  import retire_trace_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int HANG_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  t_rob_id     retire_robid,
  input  logic        retire_dst_valid,
  input  logic [4:0]  retire_dst_reg,
  input  logic [31:0] retire_dst_data,
  input  logic        retire_nuke,
  output logic        trace_valid,
  output logic [7:0]  trace_data,
  output logic        trace_last,
  input  logic        trace_ready,
  output logic [15:0] drop_total
);

  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int WDW = $clog2(HANG_TIMEOUT+1);
  localparam int RW  = $bits(t_trace_rec);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PC    = 3'd2;
  localparam logic [2:0] S_DREG  = 3'd3;
  localparam logic [2:0] S_DDATA = 3'd4;
  localparam logic [2:0] S_OVF   = 3'd5;

  logic [2:0]        r_state;
  logic [1:0]        r_idx;
  t_trace_frame_type r_ftype;
  logic [7:0]        r_pend;
  logic [7:0]        r_ovf_snap;
  logic [15:0]       r_drop_total;
  logic [WDW-1:0]    r_wd;
  logic              r_hang_pending;

  t_trace_rec        w_push_rec;
  t_trace_rec        w_head;
  logic [RW-1:0]     w_head_bits;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_drop;
  logic              w_xfer;
  logic              w_last;
  logic              w_pop;
  logic [7:0]        w_data;
  logic [7:0]        w_pend_inc;
  logic              w_unused;

  assign w_push_rec = '{pc: retire_pc, robid: retire_robid, dst_valid: retire_dst_valid,
                        dst_reg: retire_dst_reg, dst_data: retire_dst_data,
                        nuke: retire_nuke};

  // Occupancy is the registered count: a pop in the same cycle does not make
  // room. Any outstanding drop count blocks pushes until it has been reported.
  assign w_push = retire_valid && (w_count < CW'(FIFO_DEPTH)) && (r_pend == 8'd0);
  assign w_drop = retire_valid && !w_push;
  assign w_xfer = trace_valid && trace_ready;
  assign w_pop  = w_xfer && w_last && ((r_state == S_PC) || (r_state == S_DDATA));
  assign w_head = t_trace_rec'(w_head_bits);
  assign w_unused = w_head.robid[4];

  gen_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_rec),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_bits),
    .o_count     (w_count)
  );

  always_comb begin
    w_data = 8'h00;
    w_last = 1'b0;
    case (r_state)
      S_HDR: begin
        if (r_ftype == FT_RETIRE)
          w_data = make_header(FT_RETIRE, w_head.nuke, w_head.dst_valid, w_head.robid[3:0]);
        else
          w_data = make_header(r_ftype, 1'b0, 1'b0, 4'h0);
        w_last = (r_ftype == FT_HANG);
      end
      S_PC: begin
        w_data = 8'(w_head.pc >> {r_idx, 3'b000});
        w_last = (r_idx == 2'd3) && !w_head.dst_valid;
      end
      S_DREG: w_data = {3'b000, w_head.dst_reg};
      S_DDATA: begin
        w_data = 8'(w_head.dst_data >> {r_idx, 3'b000});
        w_last = (r_idx == 2'd3);
      end
      S_OVF: begin
        w_data = r_ovf_snap;
        w_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign trace_valid = (r_state != S_IDLE);
  assign trace_data  = w_data;
  assign trace_last  = w_last;
  assign drop_total  = r_drop_total;

  // Frame sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_ftype    <= FT_RETIRE;
      r_ovf_snap <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= 2'd0;
          if (w_count != '0) begin
            r_state <= S_HDR;
            r_ftype <= FT_RETIRE;
          end else if (r_pend != 8'd0) begin
            // Freeze the count so the byte cannot change while stalled.
            r_state    <= S_HDR;
            r_ftype    <= FT_OVERFLOW;
            r_ovf_snap <= r_pend;
          end else if (r_hang_pending) begin
            r_state <= S_HDR;
            r_ftype <= FT_HANG;
          end
        end
        S_HDR: if (w_xfer) begin
          r_idx <= 2'd0;
          case (r_ftype)
            FT_RETIRE:   r_state <= S_PC;
            FT_OVERFLOW: r_state <= S_OVF;
            default:     r_state <= S_IDLE;
          endcase
        end
        S_PC: if (w_xfer) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= w_head.dst_valid ? S_DREG : S_IDLE;
        end
        S_DREG: if (w_xfer) begin
          r_idx   <= 2'd0;
          r_state <= S_DDATA;
        end
        S_DDATA: if (w_xfer) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_IDLE;
        end
        S_OVF: if (w_xfer) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pend_inc = (w_drop && (r_pend != 8'hFF)) ? r_pend + 8'd1 : r_pend;

  // Drop accounting. On the count-byte transfer only the drops already
  // reported are removed; anything that arrived after the snapshot stays.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend       <= 8'd0;
      r_drop_total <= 16'd0;
    end else begin
      if ((r_state == S_OVF) && w_xfer)
        r_pend <= (r_pend - r_ovf_snap) + {7'd0, w_drop};
      else
        r_pend <= w_pend_inc;
      if (w_drop && (r_drop_total != 16'hFFFF))
        r_drop_total <= r_drop_total + 16'd1;
    end
  end

  // Watchdog: counter parks at the timeout so the hang fires only once per
  // idle period; a retire re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd           <= '0;
      r_hang_pending <= 1'b0;
    end else begin
      if ((r_state == S_HDR) && (r_ftype == FT_HANG) && w_xfer)
        r_hang_pending <= 1'b0;
      if (retire_valid) begin
        r_wd <= '0;
      end else if (r_wd != WDW'(HANG_TIMEOUT)) begin
        r_wd <= r_wd + 1'b1;
        if (r_wd == WDW'(HANG_TIMEOUT - 1)) r_hang_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/retire_trace_tx.md
RETIRE_TRACE_TX -- requirements
Module: retire_trace_tx

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 8, retire record buffer entries (power of 2, >=2); HANG_TIMEOUT, default 40, idle-retire cycles before a hang frame.
REQ-002 clk  in  1  core clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 retire_valid  in  1  one instruction retired this cycle.
REQ-005 retire_pc  in  32  PC of retired instruction.
REQ-006 retire_robid  in  t_rob_id  ROB id of retired instruction.
REQ-007 retire_dst_valid  in  1  instruction wrote a GPR.
REQ-008 retire_dst_reg  in  5  destination GPR index.
REQ-009 retire_dst_data  in  32  value written to the GPR.
REQ-010 retire_nuke  in  1  retire caused a pipeline nuke.
REQ-011 trace_valid  out  1  byte on trace_data is valid.
REQ-012 trace_data  out  8  trace stream byte.
REQ-013 trace_last  out  1  final byte of the current frame.
REQ-014 trace_ready  in  1  sink accepts the byte.
REQ-015 drop_total  out  16  saturating count of records dropped since reset.

Function
REQ-016 A byte SHALL transfer only on a cycle with trace_valid && trace_ready; trace_valid/data/last SHALL stay stable while trace_valid && !trace_ready.
REQ-017 Header byte SHALL be: [7:6] type (00 retire, 01 overflow, 10 hang, 11 reserved/never sent), [5] nuke, [4] dst_valid, [3:0] robid[3:0]; overflow and hang headers SHALL have [5:0]=0.
REQ-018 Retire frame SHALL be: header, PC bytes LSB first (4), then if dst_valid: reg byte {3'b0,reg}, data bytes LSB first (4); length 5 or 10.
REQ-019 Overflow frame SHALL be: header, then drop count since last overflow frame saturated to 8'hFF; length 2.
REQ-020 Hang frame SHALL be header only; length 1, trace_last=1.
REQ-021 A retire record SHALL be pushed only when retire_valid, FIFO occupancy < FIFO_DEPTH that cycle (a same-cycle pop does not create room), and no overflow frame is pending; otherwise dropped, incrementing pending drop count and drop_total.
REQ-022 FIFO entry SHALL pop on the cycle its last byte transfers.
REQ-023 FSM states SHALL be IDLE, HDR, PC, DREG, DDATA, OVF; a 2-bit byte index SHALL sequence PC and DDATA.
REQ-024 From IDLE, selection priority SHALL be: FIFO non-empty -> HDR (retire); else pending drops>0 -> HDR (overflow); else hang_pending -> HDR (hang); else stay.
REQ-025 Transitions: HDR->PC (retire) / OVF (overflow) / IDLE (hang); PC after byte 3 -> DREG if dst_valid else IDLE; DREG->DDATA; DDATA after byte 3 -> IDLE; OVF->IDLE; each advance only on transfer.
REQ-026 Sending an overflow frame SHALL clear the pending drop count at the transfer of its count byte; drops arriving during OVF SHALL not be lost (count cleared to the same-cycle increment).
REQ-027 Watchdog SHALL count cycles since the last retire_valid; reaching HANG_TIMEOUT SHALL set hang_pending once; retire_valid SHALL clear the counter and re-arm; hang_pending SHALL clear when the hang header transfers.
REQ-028 Latency: push at cycle N into empty FIFO with FSM in IDLE SHALL present header with trace_valid=1 at cycle N+2.
REQ-029 drop_total SHALL saturate at 16'hFFFF.

Reset
REQ-030 On reset: FIFO empty, FSM IDLE, trace_valid=0, trace_data=0, trace_last=0, drop_total=0, pending drops=0, watchdog=0, hang_pending=0; a frame in progress SHALL be abandoned, never resumed.

Structure
REQ-031 t_trace_frame_type, header field layout, and t_trace_rec SHALL live in common package.
REQ-032 Record storage SHALL be one sub-module, gen_fifo (parameterized width/depth, push/pop/count).

Verification
REQ-033 Single retire pc=0x1000, robid=0x3, dst x5=0xDEADBEEF, ready=1 -> bytes 13,00,10,00,00,05,EF,BE,AD,DE, last on 10th, header at N+2.
REQ-034 Retire without dst, nuke=1, robid=0x1F, pc=0x44 -> 2F,44,00,00,00, last on 5th.
REQ-035 ready=0, 12 back-to-back retires, then ready=1 -> 8 retire frames, then overflow frame 40,04; drop_total=4.
REQ-036 No retires for 40 cycles after reset, ready=1 -> exactly one byte 80 with last=1; none again until a retire and 40 more idle cycles.
REQ-037 ready toggling every cycle mid-frame -> byte stable while stalled, sequence identical to ready=1.
REQ-038 Reset asserted at byte 3 of a retire frame -> trace_valid=0 next cycle; next frame begins with header.
